spectrum_frame_buffer: RTL and testbench
========================================

// Module: spectrum_frame_buffer
// PURPOSE
// - Downstream of the FFT/magnitude stage. Captures the 128-bin magnitude stream
//   (one 32-bit word per mag_valid pulse, bins in order 0..127) into one of two banks.
// - Host reads a stable, complete frame over the bus while the next frame fills.
// - Optional peak-bin detector.
// PARAMETERS
// - NUM_BINS  128  bins per frame (power of two)
// - ADDR_W    7    log2(NUM_BINS)
// - DATA_W    32   magnitude word width
// PORTS
// - Bus2IP_Clk     in   1       single clock, all logic rising-edge
// - Bus2IP_Resetn  in   1       asynchronous, active-low reset
// - mag_valid      in   1       one magnitude word present this cycle
// - mag_data       in   DATA_W  magnitude word
// - frame_clr      in   1       sync: discard the partial frame, restart at bin 0
// - frame_ack      in   1       sync pulse: host done with read bank
// - rd_req         in   1       read strobe
// - rd_addr        in   ADDR_W  bin to read
// - rd_data        out  DATA_W  read data, valid only while rd_ack=1, else 0
// - rd_ack         out  1       one-cycle read acknowledge
// - frame_ready    out  1       read bank holds an un-acked complete frame
// - overrun        out  1       sticky: a frame completed while frame_ready=1
// - peak_value     out  DATA_W  max magnitude of the read-bank frame
// - peak_bin       out  ADDR_W  bin of peak_value
// BEHAVIOUR
// - Reset: all outputs 0, wr_cnt=0, wbank=0, FSM=IDLE. Bank contents undefined.
// - Write FSM:
//   - IDLE (wr_cnt=0): mag_valid -> write bin 0, wr_cnt=1, go to FILL.
//   - FILL: each mag_valid writes mem[wbank][wr_cnt], wr_cnt++.
//   - Write of bin NUM_BINS-1 = completion; go to IDLE, wr_cnt=0.
//   - No gaps needed between mag_valid pulses; no minimum spacing.
// - Completion, decided at the edge of the last write:
//   - frame_ready=0 (after any same-cycle ack) -> toggle wbank, frame_ready=1 next cycle.
//   - Else no swap; the frame is dropped, overrun=1 next cycle, and the write bank refills.
// - frame_ack: clears frame_ready and overrun next cycle.
//   - Ack in the same cycle as completion: ack applies first, then the swap.
//   - Result: frame_ready stays 1 and overrun stays 0.
// - frame_clr: wr_cnt=0, FSM=IDLE, running peak cleared.
//   - It has priority over a same-cycle mag_valid (that word is dropped).
//   - Read bank, frame_ready and overrun are unaffected.
// - Read port:
//   - rd_req at cycle N -> rd_ack=1 and rd_data=mem[rbank][rd_addr] at cycle N+1.
//   - Back-to-back rd_req gives one ack per cycle.
//   - Reads always target the read bank (~wbank). A swap at edge N is visible to a rd_req at N+1.
//   - Reading with frame_ready=0 is legal and returns the last committed frame.
// - Async reset mid-frame: partial frame lost, restart per reset values.
// CONFIGURATION
// - PEAK_DETECT_EN defined:
//   - A running max/index is kept over the write frame, strict '>' so the lowest bin wins ties.
//   - Both start at bin 0's value.
//   - On swap, they are copied to peak_value/peak_bin, updating with frame_ready.
//   - On a dropped frame, the outputs are unchanged.
// - PEAK_DETECT_EN undefined: peak_value=0, peak_bin=0 constantly; no compare logic.
// TESTING
// - Fill: 128 pulses, mag_data=3*i -> frame_ready=1 the cycle after bin 127.
//   - rd_addr=5 -> rd_data=15 with rd_ack one cycle later.
//   - Peak = 381 at bin 127.
// - Overrun: second 128-bin frame (data=1000+i), no ack -> overrun=1, frame_ready=1.
//   - rd_addr=5 still 15. After frame_ack both clear; third frame swaps in.
// - Simultaneous: frame_ack on the cycle of bin 127 -> frame_ready stays 1, overrun=0.
//   - New data is readable at N+1.
// - Clear: 60 bins, frame_clr, then 128 bins of 7+i -> bin 0 reads 7, bin 127 reads 134.
//   - frame_ready rises only after the full 128.
// - Ties (PEAK_DETECT_EN): 500 at bins 10 and 40, others 1 -> peak_value=500, peak_bin=10.
//   - Without the macro, both outputs read 0.
// - Reset: assert Bus2IP_Resetn=0 after 70 bins -> all outputs 0 immediately.
//   - Next 128 bins produce a normal frame_ready.

Source files
------------

// File: rtl/spectrum_frame_buffer.sv
// spectrum_frame_buffer: double-banked 128-bin magnitude frame capture with a host read port.
// Optional peak-bin detector enabled by defining PEAK_DETECT_EN.
module spectrum_frame_buffer #(
  parameter int NUM_BINS = 128,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 32
) (
  input  logic              Bus2IP_Clk,
  input  logic              Bus2IP_Resetn,
  input  logic              mag_valid,
  input  logic [DATA_W-1:0] mag_data,
  input  logic              frame_clr,
  input  logic              frame_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_ack,
  output logic              frame_ready,
  output logic              overrun,
  output logic [DATA_W-1:0] peak_value,
  output logic [ADDR_W-1:0] peak_bin
);
  typedef enum logic {IDLE, FILL} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] wr_cnt, wr_cnt_n;
  logic wbank, wr_en, last, complete, ready_kept, swap;
  logic [DATA_W-1:0] mem [2*NUM_BINS];
  always_comb begin
    state_n  = state;
    wr_cnt_n = wr_cnt;
    wr_en    = 1'b0;
    last     = 1'b0;
    if (frame_clr) begin
      state_n  = IDLE;
      wr_cnt_n = '0;
    end else if (mag_valid) begin
      wr_en    = 1'b1;
      last     = (state == FILL) && (wr_cnt == ADDR_W'(NUM_BINS - 1));
      wr_cnt_n = (state == IDLE) ? ADDR_W'(1) : wr_cnt + ADDR_W'(1);
      state_n  = last ? IDLE : FILL;
    end
  end
  // An ack landing on the completion edge is applied before the swap decision
  assign complete   = wr_en & last;
  assign ready_kept = frame_ready & ~frame_ack;
  assign swap       = complete & ~ready_kept;
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      state       <= IDLE;
      wr_cnt      <= '0;
      wbank       <= 1'b0;
      frame_ready <= 1'b0;
      overrun     <= 1'b0;
      rd_ack      <= 1'b0;
      rd_data     <= '0;
    end else begin
      state       <= state_n;
      wr_cnt      <= wr_cnt_n;
      wbank       <= wbank ^ swap;
      frame_ready <= ready_kept | complete;
      overrun     <= (overrun & ~frame_ack) | (complete & ready_kept);
      rd_ack      <= rd_req;
      rd_data     <= rd_req ? mem[{~wbank, rd_addr}] : '0;
    end
  end
  always_ff @(posedge Bus2IP_Clk) begin
    if (wr_en) mem[{wbank, wr_cnt}] <= mag_data;
  end
`ifdef PEAK_DETECT_EN
  logic [DATA_W-1:0] run_max, cand_max;
  logic [ADDR_W-1:0] run_idx, cand_idx;
  logic take;
  // Bin 0 seeds the running max; strict compare keeps the lowest bin on ties
  assign take     = (state == IDLE) || (mag_data > run_max);
  assign cand_max = take ? mag_data : run_max;
  assign cand_idx = take ? wr_cnt : run_idx;
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      run_max    <= '0;
      run_idx    <= '0;
      peak_value <= '0;
      peak_bin   <= '0;
    end else begin
      if (frame_clr) begin
        run_max <= '0;
        run_idx <= '0;
      end else if (wr_en) begin
        run_max <= cand_max;
        run_idx <= cand_idx;
      end
      if (swap) begin
        peak_value <= cand_max;
        peak_bin   <= cand_idx;
      end
    end
  end
`else
  assign peak_value = '0;
  assign peak_bin   = '0;
`endif
endmodule

// File: tb/tb_spectrum_frame_buffer.sv
// tb_spectrum_frame_buffer: directed checks of fill, overrun, ack/complete collision, clear, ties and reset.
module tb_spectrum_frame_buffer;
`ifdef PEAK_DETECT_EN
  localparam bit PD = 1'b1;
`else
  localparam bit PD = 1'b0;
`endif
  logic Bus2IP_Clk = 1'b0, Bus2IP_Resetn = 1'b0;
  logic mag_valid = 1'b0, frame_clr = 1'b0, frame_ack = 1'b0, rd_req = 1'b0;
  logic [31:0] mag_data = '0;
  logic [6:0] rd_addr = '0;
  logic [31:0] rd_data, peak_value;
  logic [6:0] peak_bin;
  logic rd_ack, frame_ready, overrun;
  int checks = 0, errors = 0;

  spectrum_frame_buffer dut (
    .Bus2IP_Clk(Bus2IP_Clk), .Bus2IP_Resetn(Bus2IP_Resetn),
    .mag_valid(mag_valid), .mag_data(mag_data), .frame_clr(frame_clr),
    .frame_ack(frame_ack), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_ack(rd_ack), .frame_ready(frame_ready),
    .overrun(overrun), .peak_value(peak_value), .peak_bin(peak_bin)
  );

  always #5 Bus2IP_Clk = ~Bus2IP_Clk;

  function automatic logic [31:0] pk(input logic [31:0] v);
    return PD ? v : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] d);
    mag_valid = 1'b1;
    mag_data  = d;
    @(negedge Bus2IP_Clk);
    mag_valid = 1'b0;
  endtask

  task automatic ack_pulse();
    frame_ack = 1'b1;
    @(negedge Bus2IP_Clk);
    frame_ack = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [6:0] a, input logic [31:0] exp);
    rd_req  = 1'b1;
    rd_addr = a;
    @(negedge Bus2IP_Clk);
    rd_req = 1'b0;
    chk({tag, "_ack"}, {31'd0, rd_ack}, 32'd1);
    chk(tag, rd_data, exp);
  endtask

  task automatic chk_peak(input string tag, input logic [31:0] v, input logic [31:0] b);
    chk({tag, "_peak_value"}, peak_value, pk(v));
    chk({tag, "_peak_bin"}, {25'd0, peak_bin}, pk(b));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    chk("rst_ready", {31'd0, frame_ready}, 0);
    chk("rst_overrun", {31'd0, overrun}, 0);
    chk("rst_rd_ack", {31'd0, rd_ack}, 0);
    chk("rst_rd_data", rd_data, 0);
    chk_peak("rst", 0, 0);
    @(negedge Bus2IP_Clk);
    Bus2IP_Resetn = 1'b1;
    @(negedge Bus2IP_Clk);
    for (int i = 0; i < 127; i++) push(32'(3 * i));
    chk("fill_ready_early", {31'd0, frame_ready}, 0);
    push(32'd381);
    chk("fill_ready", {31'd0, frame_ready}, 1);
    chk("fill_overrun", {31'd0, overrun}, 0);
    rd("fill_rd5", 7'd5, 32'd15);
    @(negedge Bus2IP_Clk);
    chk("idle_rd_ack", {31'd0, rd_ack}, 0);
    chk("idle_rd_data", rd_data, 0);
    chk_peak("fill", 381, 127);
    for (int i = 0; i < 128; i++) push(32'(1000 + i));
    chk("ovr_overrun", {31'd0, overrun}, 1);
    chk("ovr_ready", {31'd0, frame_ready}, 1);
    rd("ovr_rd5", 7'd5, 32'd15);
    chk_peak("ovr", 381, 127);
    ack_pulse();
    chk("ack_ready", {31'd0, frame_ready}, 0);
    chk("ack_overrun", {31'd0, overrun}, 0);
    for (int i = 0; i < 128; i++) push(32'(2000 + i));
    chk("f3_ready", {31'd0, frame_ready}, 1);
    rd("f3_rd5", 7'd5, 32'd2005);
    chk_peak("f3", 2127, 127);
    for (int i = 0; i < 127; i++) push(32'(4000 + i));
    frame_ack = 1'b1;
    push(32'd4127);
    frame_ack = 1'b0;
    chk("sim_ready", {31'd0, frame_ready}, 1);
    chk("sim_overrun", {31'd0, overrun}, 0);
    rd("sim_rd5", 7'd5, 32'd4005);
    chk_peak("sim", 4127, 127);
    ack_pulse();
    for (int i = 0; i < 60; i++) push(32'd9999);
    frame_clr = 1'b1;
    push(32'd5555);
    frame_clr = 1'b0;
    for (int i = 0; i < 127; i++) push(32'(7 + i));
    chk("clr_ready_early", {31'd0, frame_ready}, 0);
    push(32'd134);
    chk("clr_ready", {31'd0, frame_ready}, 1);
    rd("clr_rd0", 7'd0, 32'd7);
    rd("clr_rd60", 7'd60, 32'd67);
    rd("clr_rd127", 7'd127, 32'd134);
    chk_peak("clr", 134, 127);
    ack_pulse();
    for (int i = 0; i < 128; i++) push((i == 10 || i == 40) ? 32'd500 : 32'd1);
    chk("tie_ready", {31'd0, frame_ready}, 1);
    chk_peak("tie", 500, 10);
    for (int i = 0; i < 69; i++) push(32'd50);
    rd_req = 1'b1;
    push(32'd50);
    rd_req = 1'b0;
    chk("pre_rst_rd_ack", {31'd0, rd_ack}, 1);
    Bus2IP_Resetn = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, frame_ready}, 0);
    chk("mid_rst_overrun", {31'd0, overrun}, 0);
    chk("mid_rst_rd_ack", {31'd0, rd_ack}, 0);
    chk("mid_rst_rd_data", rd_data, 0);
    chk_peak("mid_rst", 0, 0);
    @(negedge Bus2IP_Clk);
    Bus2IP_Resetn = 1'b1;
    for (int i = 0; i < 127; i++) push(32'(50 + i));
    chk("post_rst_ready_early", {31'd0, frame_ready}, 0);
    push(32'd177);
    chk("post_rst_ready", {31'd0, frame_ready}, 1);
    chk("post_rst_overrun", {31'd0, overrun}, 0);
    rd("post_rst_rd3", 7'd3, 32'd53);
    chk_peak("post_rst", 177, 127);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
